// File: rtl/driver_vector_pacer_if.sv
// Vector bus seen by the pacer: read side of the upstream vector FIFO plus the
// registered vector/strobe pair consumed by the downstream trace-buffer writer.
interface driver_vector_pacer_if #(
    parameter int VECTOR_DATA_WIDTH = 192
);
    logic                         fifo_empty;
    logic [VECTOR_DATA_WIDTH-1:0] fifo_dout;
    logic                         fifo_rd_en;
    logic [VECTOR_DATA_WIDTH-1:0] vctr_fifo_data_out;
    logic                         rd_en_100ns;

    // Pacer side: consumes the FIFO, drives the trace writer.
    modport master (
        input  fifo_empty,
        input  fifo_dout,
        output fifo_rd_en,
        output vctr_fifo_data_out,
        output rd_en_100ns
    );

    // Environment side: the FIFO and the trace writer.
    modport slave (
        output fifo_empty,
        output fifo_dout,
        input  fifo_rd_en,
        input  vctr_fifo_data_out,
        input  rd_en_100ns
    );
endinterface

// File: rtl/driver_vector_pacer.sv
// Pops one vector per TICK_DIV-cycle tick and presents it registered with a one-cycle strobe.
// Build option: define DRIVER_PACER_HOLD_ON_UNDERFLOW_EN to re-strobe the held vector on underflow ticks.
module driver_vector_pacer #(
    parameter int VECTOR_DATA_WIDTH = 192,
    parameter int TICK_DIV          = 10,
    parameter int UFLOW_CNT_WIDTH   = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       ctrl_start,
    input  logic [31:0]                ctrl_vector_count,
    driver_vector_pacer_if.master      vbus,
    output logic                       busy,
    output logic                       done,
    output logic [31:0]                vectors_sent,
    output logic [UFLOW_CNT_WIDTH-1:0] underflow_cnt
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

`ifdef DRIVER_PACER_HOLD_ON_UNDERFLOW_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    function automatic logic [UFLOW_CNT_WIDTH-1:0] sat_inc(
        input logic [UFLOW_CNT_WIDTH-1:0] v
    );
        return (&v) ? v : v + 1'b1;
    endfunction

    state_t state_q, state_d;
    logic   stop_by_cnt_q, stop_by_cnt_d;

    logic [TICK_W-1:0]            tick_cnt_q, tick_cnt_d;
    logic [31:0]                  issued_q, issued_d;
    logic [31:0]                  vectors_sent_q, vectors_sent_d;
    logic [UFLOW_CNT_WIDTH-1:0]   uflow_q, uflow_d;
    logic [VECTOR_DATA_WIDTH-1:0] data_q, data_d;

    logic pop_p1_q, pop_p1_d;
    logic hold_p1_q, hold_p1_d;
    logic pop_p2_q, pop_p2_d;
    logic hold_p2_q, hold_p2_d;
    logic stb_p3_q, stb_p3_d;

    logic is_tick;
    logic cnt_reached;
    logic stop_req;
    logic tick_go;
    logic pop_go;
    logic uflow_go;
    logic in_flight;
    logic start_clear;

    // A stop seen on a tick cycle wins: that tick neither pops nor counts an underflow.
    always_comb begin
        is_tick     = (state_q == S_RUN) && (tick_cnt_q == TICK_LAST);
        cnt_reached = (ctrl_vector_count != 32'd0) && (issued_q == ctrl_vector_count);
        stop_req    = (state_q == S_RUN) && (!ctrl_start || cnt_reached);
        tick_go     = is_tick && !stop_req;
        pop_go      = tick_go && !vbus.fifo_empty;
        uflow_go    = tick_go && vbus.fifo_empty;
        in_flight   = pop_p1_q | hold_p1_q | pop_p2_q | hold_p2_q | stb_p3_q;
    end

    always_comb begin
        state_d       = state_q;
        stop_by_cnt_d = stop_by_cnt_q;
        start_clear   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (ctrl_start) begin
                    state_d     = S_RUN;
                    start_clear = 1'b1;
                end
            end
            S_RUN: begin
                if (stop_req) begin
                    state_d       = S_DRAIN;
                    // Dropping ctrl_start is treated as an abort even if the count was also met.
                    stop_by_cnt_d = ctrl_start;
                end
            end
            S_DRAIN: begin
                if (!in_flight) begin
                    state_d = stop_by_cnt_q ? S_DONE : S_IDLE;
                end
            end
            S_DONE: begin
                if (!ctrl_start) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            stop_by_cnt_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stop_by_cnt_q <= stop_by_cnt_d;
        end
    end

    always_comb begin
        tick_cnt_d = '0;
        if ((state_q == S_RUN) && !stop_req) begin
            tick_cnt_d = is_tick ? '0 : tick_cnt_q + 1'b1;
        end

        issued_d = issued_q;
        if (start_clear) begin
            issued_d = '0;
        end else if (pop_go) begin
            issued_d = issued_q + 32'd1;
        end

        uflow_d = uflow_q;
        if (start_clear) begin
            uflow_d = '0;
        end else if (uflow_go) begin
            uflow_d = sat_inc(uflow_q);
        end

        vectors_sent_d = vectors_sent_q;
        if (start_clear) begin
            vectors_sent_d = '0;
        end else if (stb_p3_q) begin
            vectors_sent_d = vectors_sent_q + 32'd1;
        end

        // Stage p1: FIFO pop (or empty slot for a held re-emit).
        pop_p1_d  = pop_go;
        hold_p1_d = HOLD_EN && uflow_go;
        // Stage p2: FIFO read data is valid this cycle and is captured at its end.
        pop_p2_d  = pop_p1_q;
        hold_p2_d = hold_p1_q;
        // Stage p3: registered vector is on the bus, strobe the writer.
        stb_p3_d  = pop_p2_q | hold_p2_q;

        data_d = data_q;
        if (pop_p2_q) begin
            data_d = vbus.fifo_dout;
        end else if (HOLD_EN && start_clear) begin
            data_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tick_cnt_q     <= '0;
            issued_q       <= '0;
            uflow_q        <= '0;
            vectors_sent_q <= '0;
            pop_p1_q       <= 1'b0;
            hold_p1_q      <= 1'b0;
            pop_p2_q       <= 1'b0;
            hold_p2_q      <= 1'b0;
            stb_p3_q       <= 1'b0;
            data_q         <= '0;
        end else begin
            tick_cnt_q     <= tick_cnt_d;
            issued_q       <= issued_d;
            uflow_q        <= uflow_d;
            vectors_sent_q <= vectors_sent_d;
            pop_p1_q       <= pop_p1_d;
            hold_p1_q      <= hold_p1_d;
            pop_p2_q       <= pop_p2_d;
            hold_p2_q      <= hold_p2_d;
            stb_p3_q       <= stb_p3_d;
            data_q         <= data_d;
        end
    end

    assign vbus.fifo_rd_en         = pop_p1_q;
    assign vbus.vctr_fifo_data_out = data_q;
    assign vbus.rd_en_100ns        = stb_p3_q;

    assign busy          = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done          = (state_q == S_DONE);
    assign vectors_sent  = vectors_sent_q;
    assign underflow_cnt = uflow_q;

endmodule

// File: tb/tb_driver_vector_pacer.sv
// Directed/randomized bench for driver_vector_pacer with a timestamp-based reference model
// and a behavioural vector FIFO.
module tb_driver_vector_pacer;

    localparam int VW = 192;
    localparam int TD = 10;
    localparam int UW = 4;
`ifdef DRIVER_PACER_HOLD_ON_UNDERFLOW_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_RUN   = 1;
    localparam int P_DRAIN = 2;
    localparam int P_DONE  = 3;

    logic          clk = 1'b0;
    logic          rstn;
    logic          ctrl_start;
    logic [31:0]   ctrl_vector_count;
    logic          busy;
    logic          done;
    logic [31:0]   vectors_sent;
    logic [UW-1:0] underflow_cnt;

    driver_vector_pacer_if #(.VECTOR_DATA_WIDTH(VW)) vif ();

    driver_vector_pacer #(
        .VECTOR_DATA_WIDTH(VW),
        .TICK_DIV         (TD),
        .UFLOW_CNT_WIDTH  (UW)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .ctrl_start       (ctrl_start),
        .ctrl_vector_count(ctrl_vector_count),
        .vbus             (vif),
        .busy             (busy),
        .done             (done),
        .vectors_sent     (vectors_sent),
        .underflow_cnt    (underflow_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural FIFO contents and reference-model state.
    logic [VW-1:0] fifo_q[$];
    int            cyc = 0;
    int            phase;
    int            run_start;
    int            last_tick;
    int            drain_exit;
    bit            by_cnt;
    int unsigned   issued;
    int            exp_rd_cyc;
    int            exp_stb_cyc;
    logic [VW-1:0] exp_stb_data;
    logic [VW-1:0] exp_hold;
    int unsigned   exp_sent;
    int            exp_uflow;
    bit            uflow_pend;
    bit            clear_pend;
    int            first_stb;
    int            stb_count;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int k = 0; k < VW / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic push(input logic [VW-1:0] v);
        fifo_q.push_back(v);
        vif.fifo_empty = 1'b0;
    endtask

    task automatic flush();
        fifo_q.delete();
        vif.fifo_empty = 1'b1;
    endtask

    task automatic model_reset();
        phase       = P_IDLE;
        run_start   = 0;
        last_tick   = -100;
        drain_exit  = 0;
        by_cnt      = 1'b0;
        issued      = 0;
        exp_rd_cyc  = -100;
        exp_stb_cyc = -100;
        exp_stb_data = '0;
        exp_hold    = '0;
        exp_sent    = 0;
        exp_uflow   = 0;
        uflow_pend  = 1'b0;
        clear_pend  = 1'b0;
    endtask

    // Decides what the block does at the end of the current cycle, from the inputs as they stand.
    task automatic decide();
        if (!rstn) begin
            model_reset();
            return;
        end
        case (phase)
            P_IDLE: begin
                if (ctrl_start) begin
                    phase      = P_RUN;
                    run_start  = cyc + 1;
                    issued     = 0;
                    last_tick  = -100;
                    clear_pend = 1'b1;
                end
            end
            P_RUN: begin
                if (!ctrl_start || (ctrl_vector_count != 0 && issued == ctrl_vector_count)) begin
                    phase      = P_DRAIN;
                    by_cnt     = ctrl_start;
                    drain_exit = (cyc + 1 > last_tick + 4) ? cyc + 1 : last_tick + 4;
                end else if ((cyc - run_start) % TD == TD - 1) begin
                    if (fifo_q.size() != 0) begin
                        exp_rd_cyc   = cyc + 1;
                        exp_stb_cyc  = cyc + 3;
                        exp_stb_data = fifo_q[0];
                        issued++;
                        last_tick    = cyc;
                    end else begin
                        uflow_pend = 1'b1;
                        if (HOLD) begin
                            exp_stb_cyc  = cyc + 3;
                            exp_stb_data = exp_hold;
                            last_tick    = cyc;
                        end
                    end
                end
            end
            P_DRAIN: begin
                if (cyc == drain_exit) phase = by_cnt ? P_DONE : P_IDLE;
            end
            default: begin
                if (!ctrl_start) phase = P_IDLE;
            end
        endcase
    endtask

    task automatic step();
        decide();
        @(negedge clk);
        cyc++;
        if (clear_pend) begin
            exp_sent  = 0;
            exp_uflow = 0;
            if (HOLD) exp_hold = '0;
            clear_pend = 1'b0;
        end
        if (uflow_pend) begin
            if (exp_uflow < (1 << UW) - 1) exp_uflow++;
            uflow_pend = 1'b0;
        end
        if (cyc == exp_stb_cyc + 1) exp_sent++;
        if (cyc == exp_stb_cyc) exp_hold = exp_stb_data;
        if (vif.fifo_rd_en === 1'b1) begin
            chk("pop_nonempty", fifo_q.size() != 0, 1'b1);
            if (fifo_q.size() != 0) vif.fifo_dout = fifo_q.pop_front();
            vif.fifo_empty = (fifo_q.size() == 0);
        end
        if (vif.rd_en_100ns === 1'b1) begin
            stb_count++;
            if (first_stb < 0) first_stb = cyc - run_start;
        end
        chk("fifo_rd_en", vif.fifo_rd_en, cyc == exp_rd_cyc);
        chk("rd_en_100ns", vif.rd_en_100ns, cyc == exp_stb_cyc);
        chk("data_out", vif.vctr_fifo_data_out, exp_hold);
        chk("busy", busy, (phase == P_RUN) || (phase == P_DRAIN));
        chk("done", done, phase == P_DONE);
        chk("vectors_sent", vectors_sent, exp_sent);
        chk("underflow_cnt", underflow_cnt, exp_uflow);
    endtask

    task automatic wait_done(input int max, input string tag);
        int n = 0;
        while (done !== 1'b1 && n < max) begin step(); n++; end
        chk(tag, done, 1'b1);
    endtask

    task automatic wait_idle(input int max, input string tag);
        int n = 0;
        while (busy !== 1'b0 && n < max) begin step(); n++; end
        chk(tag, busy, 1'b0);
    endtask

    task automatic wait_rd(input int max, input string tag);
        int n = 0;
        while (vif.fifo_rd_en !== 1'b1 && n < max) begin step(); n++; end
        chk(tag, vif.fifo_rd_en, 1'b1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        rstn = 1'b0;
        ctrl_start = 1'b0;
        ctrl_vector_count = '0;
        vif.fifo_dout = '0;
        vif.fifo_empty = 1'b1;
        first_stb = -1;
        stb_count = 0;
        model_reset();

        repeat (3) step();
        rstn = 1'b1;
        repeat (3) step();

        // Basic pacing: 5 vectors, count 5.
        for (int i = 0; i < 5; i++) push(rand_vec());
        ctrl_vector_count = 32'd5;
        ctrl_start = 1'b1;
        first_stb = -1;
        stb_count = 0;
        wait_done(120, "basic_done_timeout");
        chk("basic_first_strobe", first_stb, 12);
        chk("basic_strobe_count", stb_count, 5);
        chk("basic_vectors_sent", vectors_sent, 5);
        ctrl_start = 1'b0;
        repeat (3) step();

        // Underflow: 2 vectors, count 4, refill after a gap.
        push(rand_vec());
        push(rand_vec());
        ctrl_vector_count = 32'd4;
        ctrl_start = 1'b1;
        stb_count = 0;
        repeat (75) step();
        chk("uflow_gap_count", underflow_cnt, 5);
        push(rand_vec());
        push(rand_vec());
        wait_done(60, "uflow_done_timeout");
        chk("uflow_vectors_sent", vectors_sent, HOLD ? 9 : 4);
        chk("uflow_strobe_count", stb_count, HOLD ? 9 : 4);
        ctrl_start = 1'b0;
        repeat (3) step();

        // Restart after DONE: counters cleared, first strobe TICK_DIV+2 after entering RUN.
        push(rand_vec());
        push(rand_vec());
        ctrl_vector_count = 32'd2;
        ctrl_start = 1'b1;
        first_stb = -1;
        repeat (2) step();
        chk("restart_sent_clear", vectors_sent, 0);
        chk("restart_uflow_clear", underflow_cnt, 0);
        wait_done(60, "restart_done_timeout");
        chk("restart_first_strobe", first_stb, TD + 2);
        chk("restart_vectors_sent", vectors_sent, 2);
        ctrl_start = 1'b0;
        repeat (3) step();

        // Stop mid-run one cycle after a pop: popped vector still strobed, then IDLE.
        for (int i = 0; i < 4; i++) push(rand_vec());
        ctrl_vector_count = 32'd0;
        ctrl_start = 1'b1;
        stb_count = 0;
        wait_rd(40, "stop_pop_timeout");
        step();
        ctrl_start = 1'b0;
        wait_idle(30, "stop_idle_timeout");
        chk("stop_done_low", done, 1'b0);
        chk("stop_strobe_count", stb_count, 1);
        chk("stop_fifo_left", fifo_q.size(), 3);
        repeat (30) step();
        flush();

        // Saturation of the 4-bit underflow counter.
        ctrl_vector_count = 32'd0;
        ctrl_start = 1'b1;
        repeat (TD * 20 + 5) step();
        chk("uflow_saturated", underflow_cnt, 15);
        ctrl_start = 1'b0;
        wait_idle(30, "sat_idle_timeout");

        // Asynchronous reset in a cycle with fifo_rd_en high.
        for (int i = 0; i < 3; i++) push(rand_vec());
        ctrl_start = 1'b1;
        wait_rd(40, "rst_pop1_timeout");
        step();
        wait_rd(40, "rst_pop2_timeout");
        rstn = 1'b0;
        ctrl_start = 1'b0;
        #1;
        chk("rst_fifo_rd_en", vif.fifo_rd_en, 1'b0);
        chk("rst_rd_en_100ns", vif.rd_en_100ns, 1'b0);
        chk("rst_data_out", vif.vctr_fifo_data_out, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_vectors_sent", vectors_sent, 0);
        chk("rst_underflow_cnt", underflow_cnt, 0);
        model_reset();
        flush();
        repeat (2) step();
        rstn = 1'b1;
        repeat (30) step();
        chk("rst_stays_idle", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
